// File: rtl/shift_reg_pkg.sv
// Shared types for the command-driven universal shift register: operation
// codes, FSM state encoding and the shift-amount width helper.
package shift_reg_pkg;

   // Operation codes carried on the command interface.
   typedef enum logic [2:0] {
      ModeHold  = 3'd0,
      ModeLoad  = 3'd1,
      ModeShl   = 3'd2,
      ModeShr   = 3'd3,
      ModeRol   = 3'd4,
      ModeRor   = 3'd5,
      ModeAsr   = 3'd6,
      ModeClear = 3'd7
   } mode_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Bits needed to express a step count from 0 up to and including width.
   function automatic int unsigned shift_amt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   // True for the modes that execute as a sequence of single-bit steps.
   function automatic logic is_step_mode(input mode_e mode);
      return (mode == ModeShl) || (mode == ModeShr) || (mode == ModeRol) ||
             (mode == ModeRor) || (mode == ModeAsr);
   endfunction

endpackage

// File: rtl/shift_register_seq_if.sv
// Command/observation bundle of the shift register. The master issues
// commands and watches the register; the slave is the shift register itself.
interface shift_register_seq_if
   import shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = shift_amt_width(WIDTH)
) ();

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       mode;
   logic [WIDTH-1:0] load_data;
   logic [CW-1:0]    shift_amt;
   logic             serial_in;
   logic [WIDTH-1:0] out;
   logic             serial_out;
   logic             busy;
   logic             done;

   modport master (
      output in_valid,
      output mode,
      output load_data,
      output shift_amt,
      output serial_in,
      input  in_ready,
      input  out,
      input  serial_out,
      input  busy,
      input  done
   );

   modport slave (
      input  in_valid,
      input  mode,
      input  load_data,
      input  shift_amt,
      input  serial_in,
      output in_ready,
      output out,
      output serial_out,
      output busy,
      output done
   );

endinterface

// File: rtl/shift_reg_step.sv
// Single-bit shift/rotate step: given the current value, an operation code and
// the fill bit, produce the next value and the bit that leaves the register.
// Non-stepping modes pass the value through untouched.
module shift_reg_step
   import shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_value,
   input  mode_e            i_mode,
   input  logic             i_serial_in,
   output logic [WIDTH-1:0] o_value,
   output logic             o_bit
);

   logic w_msb;
   logic w_lsb;

   assign w_msb = i_value[WIDTH-1];
   assign w_lsb = i_value[0];

   // Next value and departing bit for one step of the selected mode.
   always_comb begin
      o_value = i_value;
      o_bit   = 1'b0;
      case (i_mode)
         ModeShl: begin
            o_value = {i_value[WIDTH-2:0], i_serial_in};
            o_bit   = w_msb;
         end
         ModeShr: begin
            o_value = {i_serial_in, i_value[WIDTH-1:1]};
            o_bit   = w_lsb;
         end
         ModeRol: begin
            o_value = {i_value[WIDTH-2:0], w_msb};
            o_bit   = w_msb;
         end
         ModeRor: begin
            o_value = {w_lsb, i_value[WIDTH-1:1]};
            o_bit   = w_lsb;
         end
         ModeAsr: begin
            // Sign bit is replicated into the vacated MSB.
            o_value = {w_msb, i_value[WIDTH-1:1]};
            o_bit   = w_lsb;
         end
         default: begin
            o_value = i_value;
            o_bit   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_register_seq.sv
// Command-driven universal shift register. One command is accepted at a time;
// LOAD/CLEAR/HOLD complete immediately, shifts and rotates run one bit per
// clock for a latched step count, then a single DONE cycle precedes the next
// accept.
module shift_register_seq
   import shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = shift_amt_width(WIDTH)
) (
   input logic                clock,
   input logic                rsnt,
   shift_register_seq_if.slave bus
);

   state_e           r_state;
   mode_e            r_mode;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_out;
   logic             r_serial_out;

   mode_e            w_cmd_mode;
   logic             w_accept;
   logic [WIDTH-1:0] w_step_value;
   logic             w_step_bit;

   assign w_cmd_mode = mode_e'(bus.mode);
   assign w_accept   = bus.in_valid && bus.in_ready;

   shift_reg_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_value     (r_out),
      .i_mode      (r_mode),
      .i_serial_in (bus.serial_in),
      .o_value     (w_step_value),
      .o_bit       (w_step_bit)
   );

   // Control FSM and datapath registers; reset wins over any operation.
   always_ff @(posedge clock) begin
      if (!rsnt) begin
         r_state      <= StIdle;
         r_mode       <= ModeHold;
         r_cnt        <= '0;
         r_out        <= '0;
         r_serial_out <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_mode <= w_cmd_mode;
                  case (w_cmd_mode)
                     ModeLoad: begin
                        r_out   <= bus.load_data;
                        r_state <= StDone;
                     end
                     ModeClear: begin
                        r_out        <= '0;
                        r_serial_out <= 1'b0;
                        r_state      <= StDone;
                     end
                     ModeHold: begin
                        r_state <= StDone;
                     end
                     default: begin
                        // A zero-length shift completes without any step.
                        if (is_step_mode(w_cmd_mode) && (bus.shift_amt != '0)) begin
                           r_cnt   <= bus.shift_amt;
                           r_state <= StRun;
                        end else begin
                           r_state <= StDone;
                        end
                     end
                  endcase
               end
            end
            StRun: begin
               r_out        <= w_step_value;
               r_serial_out <= w_step_bit;
               r_cnt        <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state <= StDone;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Status outputs decode directly from the registered state.
   assign bus.in_ready   = (r_state == StIdle) && rsnt;
   assign bus.busy       = (r_state == StRun);
   assign bus.done       = (r_state == StDone);
   assign bus.out        = r_out;
   assign bus.serial_out = r_serial_out;

endmodule

// File: doc/shift_register_seq.md
# shift_register_seq

Parametrised, command-driven universal shift register; next generation of the team's fixed 8-bit shift register. Accepts one command at a time over a valid/ready handshake: parallel load, clear, or a multi-step shift/rotate of a programmable bit count, executed one bit per clock. Sits between the counter/adder datapath and serial links, providing parallel and serial views of the same register.

## Interface
- WIDTH, 8: register width, ≥2.
- CW, $clog2(WIDTH+1): width of shift_amt.
- clock  in  1  system clock, all logic on posedge.
- rsnt  in  1  reset, synchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command.
- mode  in  3  operation code, see Operation.
- load_data  in  WIDTH  parallel value for LOAD.
- shift_amt  in  CW  number of single-bit steps for shift/rotate modes.
- serial_in  in  1  fill bit for SHL/SHR, sampled every step.
- out  out  WIDTH  register contents.
- serial_out  out  1  bit most recently shifted/rotated out.
- busy  out  1  multi-step operation in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Modes: 0 HOLD, 1 LOAD, 2 SHL (fill serial_in at bit 0), 3 SHR (fill serial_in at MSB), 4 ROL, 5 ROR, 6 ASR (MSB replicated), 7 CLEAR.
- Accept when in_valid && in_ready; mode, load_data and shift_amt are latched at the accept edge; later input changes are ignored.
- FSM states IDLE, RUN, DONE; in_ready = (state==IDLE) && rsnt.
- IDLE → DONE on accept of HOLD/LOAD/CLEAR, or of a shift/rotate with shift_amt=0; out updates at that accept edge (LOAD→load_data, CLEAR→0, others unchanged).
- IDLE → RUN on accept of a shift/rotate with shift_amt≥1; step counter loaded with shift_amt.
- RUN: one step per edge, counter decrements; after the step that takes the counter to 0 → DONE.
- DONE → IDLE unconditionally after one cycle.
- serial_out updated on every step with the departing bit (MSB for SHL/ROL, LSB for SHR/ROR/ASR); unchanged by LOAD/HOLD; cleared by CLEAR.
- shift_amt is executed literally, including values > WIDTH (SHL by WIDTH+k fills entirely with serial_in history).
- in_valid while busy or in DONE is ignored; no queueing.

## Timing
- Reset (rsnt low at an edge): out=0, serial_out=0, state=IDLE, busy=0, done=0, counter=0; takes priority over everything, including mid-RUN; an aborted operation never pulses done.
- Accept at edge k, shift amount N≥1: steps at edges k+1..k+N, busy=1 from after k through k+N, done=1 between k+N and k+N+1, in_ready=1 after k+N+1.
- Immediate ops: out valid after edge k, done=1 between k and k+1, in_ready after k+1.
- Throughput: one command per N+2 cycles (2 for immediate ops).
- busy = (state==RUN); done = (state==DONE); all outputs registered or decoded directly from state.

## Structure
- Package shift_reg_pkg: mode enum (HOLD..CLEAR, 3 bits), FSM state enum, helper for CW.
- Sub-module shift_reg_step: combinational single-step function (value, mode, serial_in → next value, departing bit), WIDTH-parametrised; top instantiates one.

## Test plan
- Reset: rsnt low 2 cycles during RUN → out=0x00, serial_out=0, busy=0, done never pulses, in_ready=1 on first cycle after release.
- LOAD 0xA5 → out=0xA5 after accept edge, done one cycle, in_ready returns next cycle; in_valid held high during DONE not re-accepted.
- From 0xA5, SHL shift_amt=3, serial_in=1 → out 0x4B, 0x97, 0x2F on successive edges; serial_out 1,0,1; busy 3 cycles; done once.
- From 0x3C, ROR shift_amt=8 → out=0x3C after 8 steps; from 0x90, ASR shift_amt=2 → 0xE4.
- shift_amt=0 with SHR on 0x5A → out stays 0x5A, done the cycle after accept, busy never asserted.
- Busy-ignore: during SHR shift_amt=5, present LOAD 0xFF with in_valid=1 → ignored, final result reflects SHR only; LOAD accepted only once in_ready returns.
